// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output stage.
//   - opcode constants produced by the upstream ALU
//   - output-stage occupancy state encoding
//   - default data / opcode widths
package alu_pkg;

  localparam int N_DEF   = 32;
  localparam int OPW_DEF = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero / negative flag generation for an N-bit value.
// Ports:
//   value : input  N-bit value (two's complement)
//   zero  : output 1 when value is all zeros
//   neg   : output 1 when value is negative (MSB set)
module alu_flag_gen #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] value,
  output logic                zero,
  output logic                neg
);

  assign zero = (value == '0);
  assign neg  = value[N-1];

endmodule

// File: rtl/alu_out_stage.sv
// Registered output stage behind the combinational ALU.
// Captures Z/op through a two-entry skid buffer (main + skid) with a
// valid/ready handshake on both sides, attaches zero/neg flags computed at
// capture time, and counts completed output transfers (wrapping).
// Ports:
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready: upstream handshake for Z/op
//   Z, op            : ALU result and the opcode that produced it
//   out_valid/out_ready: downstream handshake
//   R, R_op          : registered result / opcode (driven from main entry)
//   zero, neg        : flags of R, captured with the data
//   count            : completed output transfers modulo 2^CW
module alu_out_stage
  import alu_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int OPW = OPW_DEF,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   Z,
  input  logic [OPW-1:0] op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   R,
  output logic [OPW-1:0] R_op,
  output logic           zero,
  output logic           neg,
  output logic [CW-1:0]  count
);

  state_t state_q;
  state_t state_nx;

  logic signed [N-1:0] main_data_p0;
  logic [OPW-1:0]      main_op_p0;
  logic                main_zero_p0;
  logic                main_neg_p0;

  logic signed [N-1:0] skid_data_p0;
  logic [OPW-1:0]      skid_op_p0;
  logic                skid_zero_p0;
  logic                skid_neg_p0;

  logic [CW-1:0] count_q;

  logic z_zero;
  logic z_neg;
  logic in_xfer;
  logic out_xfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Flags are derived from the incoming result so each entry carries its own.
  alu_flag_gen #(
    .N (N)
  ) u_flag_gen (
    .value (Z),
    .zero  (z_zero),
    .neg   (z_neg)
  );

  // Handshake decode from registered state; reset blocks input acceptance.
  assign in_ready  = !rst && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx       = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_nx     = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_nx  = TWO;
        end else if (out_xfer) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path is possible.
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_nx       = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Stage p0: main / skid entry capture.
  // Entries are cleared on reset so R and flags read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_p0 <= '0;
      main_op_p0   <= '0;
      main_zero_p0 <= 1'b0;
      main_neg_p0  <= 1'b0;
      skid_data_p0 <= '0;
      skid_op_p0   <= '0;
      skid_zero_p0 <= 1'b0;
      skid_neg_p0  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_data_p0 <= Z;
        main_op_p0   <= op;
        main_zero_p0 <= z_zero;
        main_neg_p0  <= z_neg;
      end else if (load_main_skid) begin
        main_data_p0 <= skid_data_p0;
        main_op_p0   <= skid_op_p0;
        main_zero_p0 <= skid_zero_p0;
        main_neg_p0  <= skid_neg_p0;
      end
      if (load_skid) begin
        skid_data_p0 <= Z;
        skid_op_p0   <= op;
        skid_zero_p0 <= z_zero;
        skid_neg_p0  <= z_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           count_q <= '0;
    else if (out_xfer) count_q <= count_q + CW'(1);
  end

  assign R     = main_data_p0;
  assign R_op  = main_op_p0;
  assign zero  = main_zero_p0;
  assign neg   = main_neg_p0;
  assign count = count_q;

endmodule

// File: tb/tb_alu_out_stage.sv
module tb_alu_out_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Z;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;
  logic [3:0]  R_op;
  logic        zero;
  logic        neg;
  logic [15:0] count;

  // Second instance with a narrow counter for the wrap check.
  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_Z;
  logic [3:0]  w_op;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_R;
  logic [3:0]  w_R_op;
  logic        w_zero;
  logic        w_neg;
  logic [3:0]  w_count;

  int tests;
  int fails;

  alu_out_stage #(.N(32), .OPW(4), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Z         (Z),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .R_op      (R_op),
    .zero      (zero),
    .neg       (neg),
    .count     (count)
  );

  alu_out_stage #(.N(32), .OPW(4), .CW(4)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .Z         (w_Z),
    .op        (w_op),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .R         (w_R),
    .R_op      (w_R_op),
    .zero      (w_zero),
    .neg       (w_neg),
    .count     (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] srl_vec [7];
  logic [31:0] val_a, val_b, val_c, val_d, val_e;

  initial begin
    tests = 0;
    fails = 0;
    srl_vec[0] = 32'h7FFFFFFF;
    srl_vec[1] = 32'h3FFFFFFF;
    srl_vec[2] = 32'h0FFFFFFF;
    srl_vec[3] = 32'h00FFFFFF;
    srl_vec[4] = 32'h0000FFFF;
    srl_vec[5] = 32'h00000000;
    srl_vec[6] = 32'h03FFFFFF;
    val_a = 32'hAAAA0001;
    val_b = 32'h0000BBBB;
    val_c = 32'h80000000;
    val_d = 32'h12345678;
    val_e = 32'hDEADBEEF;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Z = '0;
    op = '0;
    w_in_valid = 1'b0;
    w_out_ready = 1'b0;
    w_Z = '0;
    w_op = '0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_R", R, 0);
    check("rst_R_op", R_op, 0);
    check("rst_zero", zero, 0);
    check("rst_neg", neg, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single transfer
    Z = 32'hFFFFFFFF;
    op = OP_SRL;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_R", R, 32'hFFFFFFFF);
    check("single_R_op", R_op, OP_SRL);
    check("single_neg", neg, 1);
    check("single_zero", zero, 0);
    check("single_count_before", count, 0);
    tick();
    check("single_count_after", count, 1);
    check("single_drained", out_valid, 0);
    check("single_R_hold", R, 32'hFFFFFFFF);

    // Streaming: back-to-back in and out, stays in ONE
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      Z = srl_vec[i];
      op = OP_SRL;
      tick();
      check("stream_R", R, srl_vec[i]);
      check("stream_valid", out_valid, 1);
      check("stream_zero", zero, (i == 5) ? 1 : 0);
      check("stream_neg", neg, 0);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", out_valid, 0);
    // 1 from the single transfer + 7 streamed
    check("stream_count", count, 8);

    // Backpressure with three offered results
    out_ready = 1'b0;
    in_valid = 1'b1;
    Z = val_a;
    op = OP_ADD;
    tick();
    check("bp_A_R", R, val_a);
    check("bp_A_in_ready", in_ready, 1);
    Z = val_b;
    op = OP_AND;
    tick();
    check("bp_B_in_ready", in_ready, 0);
    check("bp_B_R", R, val_a);
    check("bp_B_valid", out_valid, 1);
    Z = val_c;
    op = OP_SLT;
    tick();
    check("bp_C_held_in_ready", in_ready, 0);
    check("bp_C_R_stable", R, val_a);
    check("bp_C_Rop_stable", R_op, OP_ADD);
    out_ready = 1'b1;
    tick();
    check("bp_out_B_R", R, val_b);
    check("bp_out_B_op", R_op, OP_AND);
    check("bp_in_ready_back", in_ready, 1);
    tick();
    check("bp_out_C_R", R, val_c);
    check("bp_out_C_op", R_op, OP_SLT);
    check("bp_out_C_neg", neg, 1);
    check("bp_out_C_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_count", count, 11);

    // Mid-operation reset from TWO
    out_ready = 1'b0;
    in_valid = 1'b1;
    Z = val_d;
    op = OP_XOR;
    tick();
    Z = val_e;
    op = OP_OR;
    tick();
    check("mr_full", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_in_ready_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_count", count, 0);
    check("mr_R", R, 0);
    check("mr_R_op", R_op, 0);
    check("mr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check("mr_no_emit", out_valid, 0);
    check("mr_count_hold", count, 0);

    // Counter wrap on CW=4 instance: continuous flow
    w_in_valid = 1'b1;
    w_out_ready = 1'b1;
    w_Z = 32'h00000005;
    w_op = OP_SUB;
    tick();
    check("wrap_first_count", w_count, 0);
    check("wrap_first_valid", w_out_valid, 1);
    for (int j = 1; j <= 17; j++) begin
      tick();
      check("wrap_count", w_count, j % 16);
    end
    check("wrap_final", w_count, 1);
    w_in_valid = 1'b0;
    w_out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
